// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and defaults for the cache port arbiter and the cache controller it fronts.
package cache_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/cache_port_arbiter_rr_select.sv
// Round-robin pick: first set request bit at or above rr_ptr, wrapping to 0.
module cache_port_arbiter_rr_select #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(N_REQ);

  logic             found;
  logic [IDX_W-1:0] idx;
  int               pos;

  always_comb begin
    any       = |req_valid;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    pos       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      idx = IDX_W'(pos);
      if (!found && req_valid[idx]) begin
        grant_idx = idx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache controller among N_REQ requesters, one transaction at a time.
// States: IDLE arbitrate/latch | ISSUE start+accept pulse | WAIT await ready or timeout | RESP respond, advance pointer
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_MAX = 64
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_opcode,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      cache_start,
  output logic                      cache_opcode,
  output logic [ADDR_W-1:0]         cache_addr,
  output logic [DATA_W-1:0]         cache_wdata,
  input  logic                      cache_ready,
  input  logic [DATA_W-1:0]         cache_rdata,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  op_e               opcode_q, opcode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic              sel_any;
  logic [IDX_W-1:0]  sel_idx;
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  cache_port_arbiter_rr_select #(.N_REQ(N_REQ)) u_rr_select (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .any       (sel_any),
    .grant_idx (sel_idx)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    start_d     = 1'b0;
    busy_d      = busy_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          grant_id_d  = sel_idx;
          opcode_d    = op_e'(req_opcode[sel_idx]);
          addr_d      = addr_arr[sel_idx];
          wdata_d     = wdata_arr[sel_idx];
          req_ready_d = onehot(sel_idx);
          start_d     = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = CNT_W'(WAIT_MAX);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the terminal-count cycle still wins over the timeout.
        if (cache_ready) begin
          rsp_valid_d = onehot(grant_id_q);
          rsp_rdata_d = (opcode_q == OP_READ) ? cache_rdata : '0;
          state_d     = ST_RESP;
        end else if (wait_cnt_q == '0) begin
          rsp_valid_d = onehot(grant_id_q);
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        rr_ptr_d = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      opcode_q    <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign cache_start  = start_q;
  assign cache_opcode = opcode_q;
  assign cache_addr   = addr_q;
  assign cache_wdata  = wdata_q;
  assign busy         = busy_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-timeline model (grant cycle, start cycle, response cycle).
module tb_cache_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int WM = 8;

  logic            clk = 1'b0;
  logic            rst_b;
  logic [N-1:0]    req_valid, req_opcode, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, cache_wdata, cache_rdata;
  logic            rsp_err, cache_start, cache_opcode, cache_ready, busy;
  logic [AW-1:0]   cache_addr;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  cache_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cache_start(cache_start), .cache_opcode(cache_opcode), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_ready(cache_ready), .cache_rdata(cache_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model: one transaction descriptor plus the values the block should be holding
  int            cyc;
  bit            act;
  int            ptr, g, t_start, t_ready, t_resp, exp_gid, lat;
  bit            m_op, exp_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, rd, exp_rdata;
  int            force_lat, force_data, prev_start;
  bit            auto_clr, gap_chk;
  logic [N-1:0]  last_exp_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check_cycle();
    logic [N-1:0] er, ev;
    er = (act && cyc == t_start) ? onehot(g) : '0;
    ev = (act && cyc == t_resp)  ? onehot(g) : '0;
    last_exp_ready = er;
    chk("req_ready",    32'(req_ready),    32'(er));
    chk("cache_start",  32'(cache_start),  32'(|er));
    chk("rsp_valid",    32'(rsp_valid),    32'(ev));
    chk("busy",         32'(busy),         32'(act && cyc >= t_start && cyc <= t_resp));
    chk("grant_id",     32'(grant_id),     32'(exp_gid));
    chk("cache_opcode", 32'(cache_opcode), 32'(m_op));
    chk("cache_addr",   32'(cache_addr),   32'(m_addr));
    chk("cache_wdata",  32'(cache_wdata),  32'(m_wdata));
    if (|ev) begin
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      chk("rsp_err",   32'(rsp_err),   32'(exp_err));
    end
    if (gap_chk && cache_start === 1'b1) begin
      if (prev_start >= 0) chk("start_gap", 32'(cyc - prev_start), 32'd4);
      prev_start = cyc;
    end
  endtask

  task automatic decide();
    if (rst_b) begin
      act = 0; ptr = 0; exp_gid = 0;
      m_op = 0; m_addr = '0; m_wdata = '0;
      return;
    end
    if (act) begin
      if (cyc == t_resp) begin
        ptr = (g + 1) % N;
        act = 0;
      end
      return;
    end
    if (req_valid == '0) return;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(ptr + k) % N]) begin
        g = (ptr + k) % N;
        break;
      end
    end
    exp_gid = g;
    m_op    = req_opcode[g];
    m_addr  = req_addr[g*AW +: AW];
    m_wdata = req_wdata[g*DW +: DW];
    t_start = cyc + 1;
    if (force_lat >= 0) lat = force_lat;
    else begin
      case ($urandom_range(0, 9))
        6:       lat = 9;
        7:       lat = 10;
        8:       lat = 100;
        9:       lat = 2;
        default: lat = 1 + int'($urandom_range(0, 3));
      endcase
    end
    rd = (force_data >= 0) ? DW'(force_data) : DW'($urandom);
    // WAIT starts at t_start+1 and lasts at most WM+1 cycles before the timeout response
    if (lat - 1 <= WM) begin
      t_ready   = t_start + lat;
      t_resp    = t_ready + 1;
      exp_err   = 0;
      exp_rdata = m_op ? '0 : rd;
    end else begin
      t_ready   = -1;
      t_resp    = t_start + WM + 2;
      exp_err   = 1;
      exp_rdata = '0;
    end
    act = 1;
  endtask

  task automatic drive_cache();
    cache_ready = 1'b0;
    cache_rdata = DW'($urandom);
    if (act && cyc == t_ready) begin
      cache_ready = 1'b1;
      cache_rdata = rd;
    end else if (!(act && cyc > t_start && cyc < t_resp) && $urandom_range(0, 7) == 0) begin
      cache_ready = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    decide();
    @(posedge clk);
    #1;
    cyc++;
    drive_cache();
    if (auto_clr) req_valid = req_valid & ~last_exp_ready;
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic set_req(input int i, input bit op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_opcode[i]        = op;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    rst_b = 1'b1;
    req_valid = '0; req_opcode = '0; req_addr = '0; req_wdata = '0;
    cache_ready = 1'b0; cache_rdata = '0;
    act = 0; ptr = 0; g = 0; exp_gid = 0; m_op = 0; m_addr = '0; m_wdata = '0;
    t_start = -10; t_ready = -1; t_resp = -10;
    force_lat = -1; force_data = -1; prev_start = -1;
    auto_clr = 1; gap_chk = 0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    run(3);

    // single read from requester 2, ready 3 cycles after start
    force_lat = 3; force_data = 'hA5;
    set_req(2, 1'b0, 16'h0010, 8'h00);
    run(10);

    // round-robin from a fresh pointer, all requesters held, immediate ready
    rst_b = 1'b1; run(1); rst_b = 1'b0;
    force_lat = 1; force_data = -1; auto_clr = 0; gap_chk = 1; prev_start = -1;
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
    run(21);
    req_valid = '0; gap_chk = 0; auto_clr = 1;
    run(6);

    // pointer wrap: 3 alone, then 0 and 3 together
    set_req(3, 1'b0, 16'h0333, 8'h00);
    run(8);
    set_req(0, 1'b0, 16'h0100, 8'h00);
    set_req(3, 1'b1, 16'h0303, 8'h77);
    run(12);

    // write from requester 1
    force_lat = 2;
    set_req(1, 1'b1, 16'h00FF, 8'h3C);
    run(8);

    // timeout: no ready at all
    force_lat = 100;
    set_req(0, 1'b0, 16'h1234, 8'h00);
    run(16);

    // reset during WAIT, stray ready afterwards, next grant from pointer 0
    set_req(2, 1'b0, 16'h0BAD, 8'h00);
    run(5);
    req_valid = '0;
    rst_b = 1'b1; run(1); rst_b = 1'b0;
    cache_ready = 1'b1;
    force_lat = 2;
    set_req(0, 1'b0, 16'h0A0A, 8'h00);
    set_req(2, 1'b1, 16'h0C0C, 8'h55);
    run(12);

    // random traffic
    force_lat = -1; force_data = -1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (!(act && i == g && cyc == t_start) && $urandom_range(0, 40) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
        end
      end
      step();
    end
    req_valid = '0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
